// File: rtl/sd_decimator.sv
// Second-order CIC decoder for a 1-bit sigma-delta stream: two integrators,
// decimate by 2^K, two first-difference combs, with a two-frame warm-up gate.
module sd_decimator #(
    parameter int K = 5,
    parameter int W = 2*K+1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         clear,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    output logic         settled
);

    typedef enum logic [1:0] {WARM0, WARM1, RUN} state_t;

    state_t       r_state;
    logic [W-1:0] r_i1;
    logic [W-1:0] r_i2;
    logic [W-1:0] r_i2_d;
    logic [W-1:0] r_c1_d;
    logic [W-1:0] r_dout;
    logic [K-1:0] r_cnt;
    logic         r_dout_valid;
    logic         r_settled;

    logic [W-1:0] w_i1_next;
    logic [W-1:0] w_i2_next;
    logic [W-1:0] w_c1;
    logic [W-1:0] w_c2;

    // All sums wrap modulo 2^W; the combs cancel the wrap exactly.
    assign w_i1_next = r_i1 + {{(W-1){1'b0}}, bit_in};
    assign w_i2_next = r_i2 + w_i1_next;
    assign w_c1      = w_i2_next - r_i2_d;
    assign w_c2      = w_c1 - r_c1_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WARM0;
            r_i1         <= '0;
            r_i2         <= '0;
            r_i2_d       <= '0;
            r_c1_d       <= '0;
            r_dout       <= '0;
            r_cnt        <= '0;
            r_dout_valid <= 1'b0;
            r_settled    <= 1'b0;
        end else if (clear) begin
            r_state      <= WARM0;
            r_i1         <= '0;
            r_i2         <= '0;
            r_i2_d       <= '0;
            r_c1_d       <= '0;
            r_dout       <= '0;
            r_cnt        <= '0;
            r_dout_valid <= 1'b0;
            r_settled    <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            if (bit_valid) begin
                r_i1  <= w_i1_next;
                r_i2  <= w_i2_next;
                r_cnt <= r_cnt + 1'b1;
                // Last bit of the frame: run the combs on the updated i2.
                if (&r_cnt) begin
                    r_i2_d <= w_i2_next;
                    r_c1_d <= w_c1;
                    r_dout <= w_c2;
                    case (r_state)
                        WARM0: begin
                            r_state   <= WARM1;
                            r_settled <= 1'b0;
                        end
                        WARM1: begin
                            r_state   <= RUN;
                            r_settled <= 1'b1;
                        end
                        RUN: begin
                            r_dout_valid <= 1'b1;
                            r_settled    <= 1'b1;
                        end
                        default: begin
                            r_state   <= WARM0;
                            r_settled <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign settled    = r_settled;

endmodule

// File: tb/tb_sd_decimator.sv
// Randomised scoreboard bench for sd_decimator; the reference model is a
// triangular FIR over the accepted-bit history sampled at every frame end.
module tb_sd_decimator;
  localparam int K = 5;
  localparam int W = 2*K+1;
  localparam int R = 1 << K;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         settled;

  sd_decimator #(.K(K), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .dout(dout), .dout_valid(dout_valid), .settled(settled)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] exp_q[$];
  int           hist[$];     // accepted bits, newest first
  int           m_cnt = 0;   // accepted bits in current frame
  int           m_frames = 0;
  logic [W-1:0] m_last = '0;
  logic [W-1:0] m_e;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Combined impulse response of two length-R boxcars: 1,2,..,R,..,2,1.
  function automatic logic [W-1:0] fir_out();
    int acc = 0;
    for (int k = 0; k < hist.size(); k++) begin
      int h = (k < R) ? k + 1 : 2*R - 1 - k;
      acc += h * hist[k];
    end
    return W'(acc);
  endfunction

  task automatic model_restart();
    hist.delete();
    m_cnt = 0;
    m_frames = 0;
  endtask

  task automatic model_step(input logic b, input logic v, input logic c);
    if (c) begin
      model_restart();
    end else if (v) begin
      hist.push_front(int'(b));
      if (hist.size() > 2*R - 1) void'(hist.pop_back());
      m_cnt++;
      if (m_cnt == R) begin
        m_cnt = 0;
        if (m_frames >= 2) exp_q.push_back(fir_out());
        else m_frames++;
      end
    end
  endtask

  // driver tasks
  task automatic drive(input logic b, input logic v, input logic c);
    bit_in = b;
    bit_valid = v;
    clear = c;
    @(posedge clk);
    model_step(b, v, c);
    #1;
    check("settled", int'(settled), int'(m_frames >= 2));
    if (c) check("dout_after_clear", int'(dout), 0);
  endtask

  task automatic run_bits(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: drive(1'b1, 1'b1, 1'b0);
        1: drive(1'b0, 1'b1, 1'b0);
        2: drive(~i[0], 1'b1, 1'b0);
        3: drive(i[0], 1'b1, 1'b0);
        default: drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);
      endcase
    end
  endtask

  task automatic run_half_valid(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  // scoreboard monitor: a pulse is due exactly when the queue holds an entry
  always @(negedge clk) begin
    if (rst_n && (dout_valid || exp_q.size() != 0)) begin
      if (!dout_valid) begin
        check("dout_valid_missing", int'(dout_valid), 1);
        exp_q.delete();
      end else if (exp_q.size() == 0) begin
        check("dout_valid_extra", int'(dout_valid), 0);
      end else begin
        m_e = exp_q.pop_front();
        m_last = m_e;
        check("dout", int'(dout), int'(m_e));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", int'(dout), 0);
    check("reset_dout_valid", int'(dout_valid), 0);
    check("reset_settled", int'(settled), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_restart();

    run_bits(6*R, 0);                     // all ones
    drive(1'b0, 1'b0, 1'b1);
    run_bits(4*R, 1);                     // all zeros
    drive(1'b0, 1'b0, 1'b1);
    run_bits(5*R, 2);                     // alternating, starts with 1
    drive(1'b0, 1'b0, 1'b1);
    run_bits(5*R + 3, 3);                 // alternating, starts with 0
    drive(1'b0, 1'b0, 1'b1);
    run_half_valid(5*R);                  // stalls on every other cycle
    drive(1'b0, 1'b0, 1'b1);
    run_bits(10*R, 4);                    // random bits and valids

    // clear at cnt=17 of frame 5, with a valid bit on the clear edge
    drive(1'b0, 1'b0, 1'b1);
    run_bits(4*R + 17, 0);
    drive(1'b1, 1'b1, 1'b1);
    run_bits(3*R, 0);

    // clear coinciding with a frame end
    run_bits(R - 1, 0);
    drive(1'b1, 1'b1, 1'b1);
    run_bits(3*R, 0);

    run_bits(80*R, 0);                    // long run so both integrators wrap

    // asynchronous reset mid-frame
    run_bits(10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_dout", int'(dout), 0);
    check("async_reset_dout_valid", int'(dout_valid), 0);
    check("async_reset_settled", int'(settled), 0);
    exp_q.delete();
    model_restart();
    @(negedge clk);
    rst_n = 1'b1;
    run_bits(4*R, 0);
    run_bits(6*R, 4);

    // dout holds between frames
    repeat (5) drive(1'b1, 1'b0, 1'b0);
    check("dout_hold", int'(dout), int'(m_last));
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
